// File: rtl/coffee_io_pkg.sv
// Shared MMIO address map and field positions for the board I/O peripherals.
// Holds the button reader's event/STATUS layout and an event-word builder.
package coffee_io_pkg;

  localparam logic [15:0] HEX_ADDR        = 16'hFFFF;
  localparam logic [15:0] BTN_STATUS_ADDR = 16'hFFFC;
  localparam logic [15:0] BTN_EVENT_ADDR  = 16'hFFFD;
  localparam logic [3:0]  CHAR_RAM_PAGE   = 4'hE;

  localparam int EVT_VALID_BIT = 31;
  localparam int EVT_EDGE_BIT  = 7;
  localparam int EVT_IDX_LSB   = 0;
  localparam int EVT_IDX_MSB   = 2;
  localparam int EVT_TS_LSB    = 8;
  localparam int EVT_TS_MSB    = 23;

  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_MSB = 12;
  localparam int ST_OVF_BIT = 15;

  function automatic logic [31:0] make_event(input logic       evt_rise,
                                             input logic [2:0]  idx,
                                             input logic [15:0] ts);
    logic [31:0] ev;
    ev = '0;
    ev[EVT_VALID_BIT]             = 1'b1;
    ev[EVT_EDGE_BIT]              = evt_rise;
    ev[EVT_IDX_MSB:EVT_IDX_LSB]   = idx;
    ev[EVT_TS_MSB:EVT_TS_LSB]     = ts;
    return ev;
  endfunction

endpackage

// File: rtl/mmio_button_reader_if.sv
// CPU-side MMIO bus of the button reader: word address, write strobe/data,
// decoded select and combinational read data.
interface mmio_button_reader_if;
  logic [15:0] address;
  logic        wren;
  logic [31:0] wr_data;
  logic        sel;
  logic [31:0] rd_data;

  modport master (output address, wren, wr_data, input sel, rd_data);
  modport slave  (input address, wren, wr_data, output sel, rd_data);
endinterface

// File: rtl/mmio_button_reader_debounce.sv
// Per-button input path: 2-flop synchroniser (inverted to 1=pressed) and a
// stability counter; emits a one-cycle change pulse with the new level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_chg,
  output logic o_edge
);
  localparam int CNTW = $clog2(DEBOUNCE_CYCLES);

  logic            r_s1, r_s2, r_stable, r_chg, r_edge;
  logic [CNTW-1:0] r_cnt;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_chg    <= 1'b0;
      r_edge   <= 1'b0;
    end else begin
      r_s1  <= ~i_btn_n;
      r_s2  <= r_s1;
      r_chg <= 1'b0;
      if (r_s2 != r_stable) begin
        if (r_cnt == CNTW'(DEBOUNCE_CYCLES - 1)) begin
          r_stable <= r_s2;
          r_cnt    <= '0;
          r_chg    <= 1'b1;
          r_edge   <= r_s2;
        end else begin
          r_cnt <= r_cnt + CNTW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_stable;
  assign o_chg   = r_chg;
  assign o_edge  = r_edge;
endmodule

// File: rtl/mmio_button_reader.sv
// Memory-mapped button reader: debounced levels, press/release event FIFO,
// STATUS/EVENT register decode. Optional event timestamps via BTN_TIMESTAMP_EN.
module mmio_button_reader
  import coffee_io_pkg::*;
#(
  parameter int          N_BTN           = 3,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] BASE_ADDR       = BTN_STATUS_ADDR,
  parameter int          TICK_CYCLES     = 50000
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [N_BTN-1:0]     btn_n,
  output logic [N_BTN-1:0]     level,
  mmio_button_reader_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [15:0] EVT_ADDR = BASE_ADDR + 16'd1;

  logic [N_BTN-1:0] w_level, w_chg, w_edge, w_clr;
  logic [N_BTN-1:0] r_pend, r_pedge;
  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             w_req, w_rise, w_full, w_push, w_pop, w_drop, w_clr_ovf;
  logic [2:0]       w_idx;
  logic [15:0]      w_ts;
  logic [31:0]      w_status;
  logic             w_unused_wr;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock   (clock),
      .rst     (rst),
      .i_btn_n (btn_n[g]),
      .o_level (w_level[g]),
      .o_chg   (w_chg[g]),
      .o_edge  (w_edge[g])
    );
  end

`ifdef BTN_TIMESTAMP_EN
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  logic [TW-1:0] r_pre;
  logic [15:0]   r_ts;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_ts  <= '0;
    end else if (r_pre == TW'(TICK_CYCLES - 1)) begin
      r_pre <= '0;
      r_ts  <= r_ts + 16'd1;
    end else begin
      r_pre <= r_pre + TW'(1);
    end
  end
  assign w_ts = r_ts;
`else
  logic w_unused_tick;
  assign w_unused_tick = ^TICK_CYCLES;
  assign w_ts = '0;
`endif

  // Lowest-index pending button wins; it is cleared whether or not the push lands.
  always_comb begin
    w_req  = 1'b0;
    w_idx  = '0;
    w_rise = 1'b0;
    w_clr  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (r_pend[i] && !w_req) begin
        w_req    = 1'b1;
        w_idx    = 3'(i);
        w_rise   = r_pedge[i];
        w_clr[i] = 1'b1;
      end
    end
  end

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = bus.wren && (bus.address == EVT_ADDR) && (r_count != '0);
  assign w_push    = w_req && (!w_full || w_pop);
  assign w_drop    = w_req && w_full && !w_pop;
  assign w_clr_ovf = bus.wren && (bus.address == BASE_ADDR) && bus.wr_data[ST_OVF_BIT];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_pend  <= '0;
      r_pedge <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_chg;
      for (int i = 0; i < N_BTN; i++)
        if (w_chg[i]) r_pedge[i] <= w_edge[i];
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_clr_ovf) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wp] <= make_event(w_rise, w_idx, w_ts);
  end

  always_comb begin
    w_status = '0;
    w_status[N_BTN-1:0]             = w_level;
    w_status[ST_CNT_MSB:ST_CNT_LSB] = 5'(r_count);
    w_status[ST_OVF_BIT]            = r_ovf;
  end

  assign bus.sel = (bus.address == BASE_ADDR) || (bus.address == EVT_ADDR);

  always_comb begin
    bus.rd_data = '0;
    if (bus.address == BASE_ADDR)
      bus.rd_data = w_status;
    else if (bus.address == EVT_ADDR && r_count != '0)
      bus.rd_data = r_mem[r_rp];
  end

  assign level       = w_level;
  assign w_unused_wr = ^{bus.wr_data[31:16], bus.wr_data[14:0]};
endmodule

// File: tb/tb_mmio_button_reader.sv
// Directed bench for mmio_button_reader (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4,
// TICK_CYCLES=2, timestamps off): reset, press, glitch, arbitration, overflow.
module tb_mmio_button_reader;
  localparam logic [15:0] ST = 16'hFFFC;
  localparam logic [15:0] EV = 16'hFFFD;

  logic       clock = 1'b0;
  logic       rst;
  logic [2:0] btn_n;
  logic [2:0] level;
  int         n_chk  = 0;
  int         n_fail = 0;

  mmio_button_reader_if bus();

  mmio_button_reader #(
    .N_BTN(3), .DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4),
    .BASE_ADDR(16'hFFFC), .TICK_CYCLES(2)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .btn_n (btn_n),
    .level (level),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    check(tag, bus.rd_data, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    bus.address = a;
    bus.wr_data = d;
    bus.wren    = 1'b1;
    tick(1);
    bus.wren    = 1'b0;
    bus.wr_data = '0;
  endtask

  initial begin
    rst = 1'b1; btn_n = 3'b111;
    bus.address = '0; bus.wren = 1'b0; bus.wr_data = '0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // 1: reset mid-debounce
    btn_n = 3'b101;
    tick(4);
    rst = 1'b1;
    #1;
    check("rst_level", {29'd0, level}, 32'h0);
    rd_chk("rst_status", ST, 32'h0);
    rd_chk("rst_event", EV, 32'h0);
    check("rst_sel_st", {31'd0, bus.sel}, 32'h1);
    bus.address = 16'h1234; #1;
    check("sel_off", {31'd0, bus.sel}, 32'h0);
    check("rd_off", bus.rd_data, 32'h0);
    btn_n = 3'b111;
    tick(2);
    rst = 1'b0;
    tick(10);
    rd_chk("post_rst_status", ST, 32'h0);

    // 2: press btn1, accept after 6 cycles
    btn_n = 3'b101;
    tick(5);
    check("press_lvl_5", {29'd0, level}, 32'h0);
    tick(1);
    check("press_lvl_6", {29'd0, level}, 32'h2);
    tick(4);
    rd_chk("press_status", ST, 32'h0000_0102);
    rd_chk("press_event", EV, 32'h8000_0081);
    btn_n = 3'b111;
    tick(10);
    rd_chk("rel_status", ST, 32'h0000_0200);
    wr(EV, 32'h0);
    rd_chk("rel_event", EV, 32'h8000_0001);
    wr(EV, 32'h0);
    rd_chk("drain_event", EV, 32'h0);
    wr(EV, 32'hFFFF_FFFF);
    rd_chk("pop_empty", ST, 32'h0);

    // 3: 3-cycle glitch on btn0
    btn_n = 3'b110;
    tick(3);
    btn_n = 3'b111;
    tick(10);
    rd_chk("glitch_status", ST, 32'h0);

    // 4: btn0 and btn2 together
    btn_n = 3'b010;
    tick(8);
    rd_chk("arb_cnt1", ST, 32'h0000_0105);
    tick(1);
    rd_chk("arb_cnt2", ST, 32'h0000_0205);
    rd_chk("arb_head0", EV, 32'h8000_0080);
    wr(EV, 32'h0);
    rd_chk("arb_head2", EV, 32'h8000_0082);
    wr(EV, 32'h0);
    rd_chk("arb_empty", EV, 32'h0);
    rd_chk("arb_status", ST, 32'h0000_0005);
    btn_n = 3'b111;
    tick(12);
    rd_chk("arb_rel0", EV, 32'h8000_0000);
    wr(EV, 32'h0);
    rd_chk("arb_rel2", EV, 32'h8000_0002);
    wr(EV, 32'h0);
    rd_chk("arb_drain", ST, 32'h0);

    // 5: six edges, no pops
    for (int k = 0; k < 6; k++) begin
      btn_n = (k % 2 == 0) ? 3'b101 : 3'b111;
      tick(10);
    end
    rd_chk("ovf_status", ST, 32'h0000_8400);
    rd_chk("ovf_head", EV, 32'h8000_0081);
    wr(ST, 32'h0000_7FFF);
    rd_chk("ovf_keep", ST, 32'h0000_8400);
    wr(ST, 32'h0000_8000);
    rd_chk("ovf_clear", ST, 32'h0000_0400);

    // 6: pop and push in the same cycle while full
    btn_n = 3'b011;
    tick(7);
    wr(EV, 32'h0);
    rd_chk("full_pp_status", ST, 32'h0000_0404);
    rd_chk("full_pp_head1", EV, 32'h8000_0001);
    wr(EV, 32'h0);
    rd_chk("full_pp_head2", EV, 32'h8000_0081);
    wr(EV, 32'h0);
    rd_chk("full_pp_head3", EV, 32'h8000_0001);
    wr(EV, 32'h0);
    rd_chk("full_pp_tail", EV, 32'h8000_0082);

    // reset with FIFO non-empty and btn0 mid-debounce
    btn_n = 3'b010;
    tick(3);
    rst = 1'b1;
    #1;
    rd_chk("rst2_status", ST, 32'h0);
    rd_chk("rst2_event", EV, 32'h0);
    btn_n = 3'b111;
    tick(2);
    rst = 1'b0;
    tick(10);
    rd_chk("rst2_after", ST, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
